// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags: write/read requests, data,
// occupancy, threshold flags and error pulses.
interface sync_fifo_flags_if #(
  parameter int dwidth = 8,
  parameter int dsize  = 8
);
  localparam int CW = $clog2(dsize) + 1;

  logic              we;
  logic [dwidth-1:0] din;
  logic              re;
  logic [dwidth-1:0] dout;
  logic              d_full;
  logic              d_empty;
  logic              d_afull;
  logic              d_aempty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output we, din, re,
    input  dout, d_full, d_empty, d_afull, d_aempty, count, overflow, underflow
  );

  modport slave (
    input  we, din, re,
    output dout, d_full, d_empty, d_afull, d_aempty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// overflow/underflow pulses and selectable registered or FWFT read.
module sync_fifo_flags #(
  parameter int dsize  = 8,
  parameter int dwidth = 8,
  parameter int af_lvl = dsize - 2,
  parameter int ae_lvl = 2,
  parameter int fwft   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_fifo_flags_if.slave     bus
);
  localparam int AW = $clog2(dsize);
  localparam int CW = AW + 1;

  logic [dwidth-1:0] r_mem [dsize];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_full  = (r_count == CW'(dsize));
  assign w_empty = (r_count == '0);
  assign w_rd_ok = bus.re & ~w_empty;
  // a write into a full FIFO is only legal when a read frees a slot this cycle
  assign w_wr_ok = bus.we & (~w_full | w_rd_ok);

  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[r_wptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_rd_ok) r_rptr <= r_rptr + AW'(1);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_ovf <= bus.we & ~w_wr_ok;
      r_udf <= bus.re & ~w_rd_ok;
    end
  end

  generate
    if (fwft != 0) begin : g_fwft
      assign bus.dout = w_empty ? '0 : r_mem[r_rptr];
    end else begin : g_std
      logic [dwidth-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= '0;
        end else if (w_rd_ok) begin
          r_dout <= r_mem[r_rptr];
        end
      end
      assign bus.dout = r_dout;
    end
  endgenerate

  assign bus.d_full    = w_full;
  assign bus.d_empty   = w_empty;
  assign bus.d_afull   = (r_count >= CW'(af_lvl));
  assign bus.d_aempty  = (r_count <= CW'(ae_lvl));
  assign bus.count     = r_count;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_udf;
endmodule
